// File: rtl/spi_fpmul_pkg.sv
// Shared definitions for the SPI half-precision multiplier master and slave.
// Holds operand/transfer widths, default timing parameters and the master
// FSM state encoding.
package spi_fpmul_pkg;

    localparam int unsigned OP_W            = 16;
    localparam int unsigned XFER_W          = 2 * OP_W;
    localparam int unsigned DEF_CLK_DIV     = 4;
    localparam int unsigned DEF_WAIT_CYCLES = 16;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StCsSetup  = 3'd1,
        StShiftOut = 3'd2,
        StWaitY    = 3'd3,
        StShiftIn  = 3'd4,
        StCsHold   = 3'd5,
        StDone     = 3'd6
    } state_e;

endpackage

// File: rtl/spi_fpmul_master_if.sv
// Request and SPI bus bundle for spi_fpmul_master.
//   start/a/b      : local request (operands captured on accepted start)
//   busy/done/result : local status and product
//   sck/mosi/cs    : SPI outputs of the master, miso : SPI input
// Modport master is the DUT view; modport slave is the opposite side.
interface spi_fpmul_master_if;
    import spi_fpmul_pkg::*;

    logic            start;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            busy;
    logic            done;
    logic [OP_W-1:0] result;
    logic            sck;
    logic            mosi;
    logic            miso;
    logic            cs;

    modport master (
        input  start, a, b, miso,
        output busy, done, result, sck, mosi, cs
    );

    modport slave (
        output start, a, b, miso,
        input  busy, done, result, sck, mosi, cs
    );

endinterface

// File: rtl/spi_sck_gen.sv
// SPI clock generator for spi_fpmul_master.
//   clk, rst_n : system clock, async active-low reset
//   shift_out  : FSM in write phase (each bit: low half then high half)
//   shift_in   : FSM in read phase (each bit: high half then low half)
//   in_start   : last WAIT_Y cycle; sck rises on the following edge
//   last_bit   : current read bit is the final one (no further rise)
//   tick       : last clk cycle of the current half-period
//   sck        : registered SPI clock, idle low
//   rise/fall  : sck changes 0->1 / 1->0 at the end of this cycle
//   sample     : last cycle of a read low half; miso is sampled now
module spi_sck_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic shift_out,
    input  logic shift_in,
    input  logic in_start,
    input  logic last_bit,
    input  logic tick,
    output logic sck,
    output logic rise,
    output logic fall,
    output logic sample
);

    logic sck_q, sck_d;

    always_comb begin
        sck_d = 1'b0;
        if (in_start) begin
            sck_d = 1'b1;
        end else if (shift_out) begin
            sck_d = tick ? ~sck_q : sck_q;
        end else if (shift_in) begin
            // After the final low half sck stays low for CS_HOLD.
            sck_d = tick ? (~sck_q & ~last_bit) : sck_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= 1'b0;
        end else begin
            sck_q <= sck_d;
        end
    end

    assign sck    = sck_q;
    assign rise   = ~sck_q & sck_d;
    assign fall   = sck_q & ~sck_d;
    assign sample = shift_in & tick & ~sck_q;

endmodule

// File: rtl/spi_fpmul_master.sv
// SPI mode-0 master for the half-precision multiplier slave.
// Shifts out {a,b} MSB first, idles SCK for WAIT_CYCLES while the slave
// computes, clocks in the 16-bit product and reports it with a done pulse.
//   clk, rst_n : system clock, async active-low reset
//   bus        : request/status and SPI signals (master modport)
module spi_fpmul_master
    import spi_fpmul_pkg::*;
#(
    parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_fpmul_master_if.master bus
);

    localparam int unsigned DivW  = $clog2(CLK_DIV);
    localparam int unsigned WaitW = $clog2(WAIT_CYCLES + 1);

    state_e              state_q, state_d;
    logic [DivW-1:0]     div_q, div_d;
    logic [5:0]          bit_q, bit_d;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic [XFER_W-1:0]   sout_q, sout_d;
    logic [OP_W-1:0]     sin_q, sin_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [OP_W-1:0]     result_q, result_d;

    logic tick, div_run, wait_last, last_in_bit;
    logic sck, sck_rise, sck_fall, sck_sample;

    assign tick        = (div_q == DivW'(CLK_DIV - 1));
    assign div_run     = (state_q == StCsSetup) || (state_q == StShiftOut) ||
                         (state_q == StShiftIn) || (state_q == StCsHold);
    assign wait_last   = (wait_q == WaitW'(WAIT_CYCLES - 1));
    assign last_in_bit = (bit_q == 6'(OP_W - 1));

    spi_sck_gen u_sck_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_out (state_q == StShiftOut),
        .shift_in  (state_q == StShiftIn),
        .in_start  ((state_q == StWaitY) && wait_last),
        .last_bit  (last_in_bit),
        .tick      (tick),
        .sck       (sck),
        .rise      (sck_rise),
        .fall      (sck_fall),
        .sample    (sck_sample)
    );

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        wait_d   = wait_q;
        sout_d   = sout_q;
        sin_d    = sin_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        // Every state transition that uses the divider happens on tick,
        // so the wrap to zero also aligns the next phase.
        if (div_run) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sout_d  = {bus.a, bus.b};
                    busy_d  = 1'b1;
                    state_d = StCsSetup;
                end
            end
            StCsSetup: begin
                if (tick) state_d = StShiftOut;
            end
            StShiftOut: begin
                // mosi advances together with the falling sck edge.
                if (sck_fall) begin
                    sout_d = {sout_q[XFER_W-2:0], 1'b0};
                    if (bit_q == 6'(XFER_W - 1)) begin
                        bit_d   = '0;
                        state_d = StWaitY;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StWaitY: begin
                if (wait_last) begin
                    wait_d  = '0;
                    state_d = StShiftIn;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StShiftIn: begin
                if (sck_sample) begin
                    sin_d = {sin_q[OP_W-2:0], bus.miso};
                    if (last_in_bit) begin
                        bit_d   = '0;
                        state_d = StCsHold;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StCsHold: begin
                if (tick) state_d = StDone;
            end
            StDone: begin
                result_d = sin_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            div_q    <= '0;
            bit_q    <= '0;
            wait_q   <= '0;
            sout_q   <= '0;
            sin_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            wait_q   <= wait_d;
            sout_q   <= sout_d;
            sin_q    <= sin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // cs and mosi decode straight from state so reset releases them at once.
    assign bus.cs     = ~((state_q == StCsSetup) || (state_q == StShiftOut) ||
                          (state_q == StWaitY)   || (state_q == StShiftIn));
    assign bus.mosi   = ((state_q == StCsSetup) || (state_q == StShiftOut)) &
                        sout_q[XFER_W-1];
    assign bus.sck    = sck;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

    sck_rise_in_window: assert property (@(posedge clk) disable iff (!rst_n)
        sck_rise |-> !bus.cs);

endmodule

// File: tb/tb_spi_fpmul_master.sv
module tb_spi_fpmul_master;

    logic clk;
    logic rst_n;

    spi_fpmul_master_if if0 ();
    spi_fpmul_master_if if1 ();

    spi_fpmul_master #(.CLK_DIV(4), .WAIT_CYCLES(16)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    spi_fpmul_master #(.CLK_DIV(6), .WAIT_CYCLES(40)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Monitor + MISO stub for dut0, sampled on the falling clk edge.
    logic        mon_clr;
    logic [15:0] resp0;
    logic [31:0] cap0;
    int          rises0, falls0, wr_n0, win0, mosi_bad0, sck_bad0, done_n0;
    logic        p_sck0, p_mosi0, p_cs0;

    always @(negedge clk) begin
        if (mon_clr) begin
            rises0 = 0; falls0 = 0; wr_n0 = 0; win0 = 0;
            mosi_bad0 = 0; sck_bad0 = 0; done_n0 = 0;
            cap0 = '0;
            if0.miso = 1'b0;
        end else begin
            if (if0.sck && !p_sck0) begin
                rises0++;
                if (wr_n0 < 32) begin
                    cap0 = {cap0[30:0], if0.mosi};
                    wr_n0++;
                end
            end
            if (!if0.sck && p_sck0) begin
                if (falls0 >= 32 && falls0 < 48) if0.miso = resp0[4'(47 - falls0)];
                falls0++;
            end
            if (!if0.cs && p_cs0) win0++;
            if ((if0.mosi !== p_mosi0) && if0.sck) mosi_bad0++;
            if ((if0.sck !== p_sck0) && if0.cs) sck_bad0++;
            if (if0.done) done_n0++;
        end
        p_sck0  = if0.sck;
        p_mosi0 = if0.mosi;
        p_cs0   = if0.cs;
    end

    // Monitor + MISO stub for dut1: also measures the first sck high half.
    logic        mon1_clr;
    logic [15:0] resp1;
    int          falls1, run1, half1;
    logic        got1, p_sck1;

    always @(negedge clk) begin
        if (mon1_clr) begin
            falls1 = 0; run1 = 0; half1 = 0; got1 = 1'b0;
            if1.miso = 1'b0;
        end else begin
            if (if1.sck && !p_sck1) run1 = 1;
            else if (if1.sck) run1++;
            if (!if1.sck && p_sck1) begin
                if (!got1) begin
                    half1 = run1;
                    got1  = 1'b1;
                end
                if (falls1 >= 32 && falls1 < 48) if1.miso = resp1[4'(47 - falls1)];
                falls1++;
            end
        end
        p_sck1 = if1.sck;
    end

    // Call #1 after a posedge; returns #1 after the edge that samples start.
    task automatic start_xfer(input logic [15:0] ta, input logic [15:0] tb_v,
                              input logic [15:0] rsp, output logic acc_busy);
        resp0     = rsp;
        if0.a     = ta;
        if0.b     = tb_v;
        if0.start = 1'b1;
        mon_clr   = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        mon_clr   = 1'b0;
        acc_busy  = if0.busy;
    endtask

    // Counts edges after acceptance until done; optional busy-time start poke.
    task automatic wait_done(input bit poke, input int limit, output int lat);
        lat = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke && lat == 100) begin
                if0.start = 1'b1;
                if0.a     = 16'hFFFF;
                if0.b     = 16'hFFFF;
            end
            if (poke && lat == 101) if0.start = 1'b0;
            if (if0.done) break;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic acc;

        rst_n     = 1'b0;
        mon_clr   = 1'b1;
        mon1_clr  = 1'b1;
        if0.start = 1'b0; if0.a = '0; if0.b = '0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0;
        resp0 = '0;
        resp1 = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs",     32'(if0.cs),     32'h1);
        check("rst_sck",    32'(if0.sck),    32'h0);
        check("rst_mosi",   32'(if0.mosi),   32'h0);
        check("rst_busy",   32'(if0.busy),   32'h0);
        check("rst_done",   32'(if0.done),   32'h0);
        check("rst_result", 32'(if0.result), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1.0 * 2.0 = 2.0, with an ignored start and operand change mid-transfer.
        start_xfer(16'h3C00, 16'h4000, 16'h4000, acc);
        check("t1_busy_accept", 32'(acc), 32'h1);
        wait_done(1'b1, 2000, lat);
        check("t1_latency", 32'(lat),        32'd409);
        check("t1_result",  32'(if0.result), 32'h4000);
        check("t1_busy_at_done", 32'(if0.busy), 32'h0);
        check("t1_mosi_word", cap0,          32'h3C004000);
        check("t1_rises",   32'(rises0),     32'd48);
        check("t1_falls",   32'(falls0),     32'd48);
        check("t1_cs_windows", 32'(win0),    32'd1);
        check("t1_mosi_in_high", 32'(mosi_bad0), 32'd0);
        check("t1_sck_cs_high",  32'(sck_bad0),  32'd0);
        @(negedge clk);
        #1;
        check("t1_done_count", 32'(done_n0), 32'd1);
        check("t1_done_pulse", 32'(if0.done), 32'h1);
        @(posedge clk);
        #1;

        // Start in the cycle right after done; MOSI pattern and 0xBEEF read.
        start_xfer(16'hA5A5, 16'h0F0F, 16'hBEEF, acc);
        check("t2_accept_after_done", 32'(acc), 32'h1);
        wait_done(1'b0, 2000, lat);
        check("t2_latency", 32'(lat),        32'd409);
        check("t2_result",  32'(if0.result), 32'hBEEF);
        check("t2_busy_at_done", 32'(if0.busy), 32'h0);
        check("t2_mosi_word", cap0,          32'hA5A50F0F);
        check("t2_rises",   32'(rises0),     32'd48);
        check("t2_cs_windows", 32'(win0),    32'd1);
        check("t2_mosi_in_high", 32'(mosi_bad0), 32'd0);
        @(posedge clk);
        #1;

        // Reset during the high half of write bit 10 (edge 90 after accept).
        start_xfer(16'h1234, 16'h5678, 16'h0000, acc);
        repeat (89) @(posedge clk);
        #1;
        check("t3_sck_before_rst", 32'(if0.sck), 32'h1);
        check("t3_cs_before_rst",  32'(if0.cs),  32'h0);
        rst_n = 1'b0;
        #1;
        check("t3_rst_cs",   32'(if0.cs),   32'h1);
        check("t3_rst_sck",  32'(if0.sck),  32'h0);
        check("t3_rst_busy", 32'(if0.busy), 32'h0);
        check("t3_rst_mosi", 32'(if0.mosi), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        check("t3_no_done", 32'(done_n0), 32'd0);

        // Normal transfer after the abort: 1.0 * 1.0 = 1.0.
        start_xfer(16'h3C00, 16'h3C00, 16'h3C00, acc);
        wait_done(1'b0, 2000, lat);
        check("t4_latency", 32'(lat),        32'd409);
        check("t4_result",  32'(if0.result), 32'h3C00);
        check("t4_mosi_word", cap0,          32'h3C003C00);

        // CLK_DIV=6, WAIT_CYCLES=40: -2.0 * 0.5 = -1.0.
        @(posedge clk);
        #1;
        resp1     = 16'hBC00;
        if1.a     = 16'hC000;
        if1.b     = 16'h3800;
        if1.start = 1'b1;
        mon1_clr  = 1'b1;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        mon1_clr  = 1'b0;
        lat = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (if1.done) break;
        end
        check("t5_latency",   32'(lat),        32'd629);
        check("t5_result",    32'(if1.result), 32'hBC00);
        check("t5_sck_half",  32'(half1),      32'd6);
        check("t5_falls",     32'(falls1),     32'd48);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_fpmul_master.md
Name: spi_fpmul_master

Overview:
SPI master (mode 0, MSB first) that drives the SPI-attached half-precision multiplier slave from a local request interface. On start it asserts cs, shifts out operand a then operand b (32 contiguous bits), idles SCK for a fixed wait while the slave computes, then clocks in the 16-bit product and returns it with a done pulse. It sits on the host/test side, opposite the fpmul SPI slave, in the same clk domain.

Parameters:
CLK_DIV, 4, SCK half-period in clk cycles; legal values are >= 4, which covers the slave's SCK synchroniser and MISO register latency.
WAIT_CYCLES, 16, clk cycles with cs low and SCK low between the last write bit and the first read pulse; must exceed the slave multiplier latency.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only when busy=0
a  in  16  operand x1, captured on accepted start
b  in  16  operand x2, captured on accepted start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; result valid from this cycle
result  out  16  product, held until the next done
sck  out  1  SPI clock, idle low
mosi  out  1  master out
miso  in  1  master in
cs  out  1  chip select, active low

Behaviour:
- Reset (async, rst_n=0): cs=1, sck=0, mosi=0, busy=0, done=0, result=0, state IDLE, all counters 0. Reset mid-transfer aborts immediately: cs rises and sck falls in the same instant; no done is produced.
- Internal div counter counts 0..CLK_DIV-1 and marks half-period boundaries. Bit counter is 6 bits wide. Shift-out register is 32 bits, loaded {a,b}. Shift-in register is 16 bits.
- IDLE: if start, load {a,b}, busy<=1, and go to CS_SETUP. Start while busy=1 is ignored with no effect.
- CS_SETUP (CLK_DIV cycles): cs=0, sck=0, mosi=bit31.
- SHIFT_OUT (32 bits x 2*CLK_DIV cycles):
  - Each bit is a low half followed by a high half.
  - sck rises at the start of the high half; the slave samples on this rising edge.
  - At the end of the high half, sck falls and mosi advances to the next bit.
  - After bit 0's high half, sck=0 and the state goes to WAIT_Y.
- WAIT_Y (WAIT_CYCLES cycles): cs=0, sck=0, mosi=0.
- SHIFT_IN (16 bits x 2*CLK_DIV cycles):
  - Each bit is a high half followed by a low half.
  - The slave drives the bit after the falling edge.
  - The master samples miso in the last clk cycle of each low half and shifts it in MSB first.
- CS_HOLD (CLK_DIV cycles): cs=1, sck=0.
- DONE (1 cycle): result<=shift-in register, done=1, busy=0, then return to IDLE. start is accepted again in the cycle after done.
- Total latency: done is asserted 98*CLK_DIV+WAIT_CYCLES+1 clk cycles after the edge that accepts start. For the defaults this is 409 cycles.
- cs stays low continuously from CS_SETUP through the end of SHIFT_IN; there is exactly one cs-low window per transaction.
- Exactly 48 sck rising edges and 48 sck falling edges per transaction. sck never toggles while cs=1.
- mosi changes only while sck=0.
- a and b changing during busy has no effect.

Decomposition:
- Shared package spi_fpmul_pkg holds:
  - the state encoding localparams (IDLE, CS_SETUP, SHIFT_OUT, WAIT_Y, SHIFT_IN, CS_HOLD, DONE);
  - OP_W=16 and XFER_W=32;
  - the default CLK_DIV and WAIT_CYCLES.
- The slave imports OP_W from the same package.
- One sub-module is natural: spi_sck_gen. It takes the div counter and the half-period tick as inputs and produces sck plus rise/fall/sample strobes. The FSM stays in the top module.

Test Plan:
- Loopback with the fpmul SPI slave and a behavioural multiplier model (ready 8 cycles after en): a=0x3C00, b=0x4000 -> result=0x4000, done asserted exactly 409 cycles after start.
- MOSI capture monitor: a=0xA5A5, b=0x0F0F -> bits sampled on the 32 write rising edges are 0xA5A50F0F MSB first; 48 sck pulses total; cs low in a single window.
- MISO stub that drives 0xBEEF on successive falling edges -> result=0xBEEF; busy falls in the same cycle as done.
- start pulsed again at cycle 100 while busy -> ignored; exactly one done per accepted start. A start in the cycle after done is accepted.
- rst_n=0 during SHIFT_OUT bit 10 -> cs=1, sck=0, busy=0 immediately and no done. A subsequent start completes normally with a correct result.
- CLK_DIV=6, WAIT_CYCLES=40 -> sck half-period is 6 cycles; result is correct for a=0xC000, b=0x3800 (-2.0*0.5 = 0xBC00).
